// File: rtl/craft_decrypt_if.sv
// Handshake and operand bundle for the CRAFT-64 decryption core.
// The master drives a start pulse with operands; the slave returns busy/done/plaintext.
interface craft_decrypt_if;
  logic         start;
  logic [63:0]  ciphertext;
  logic [63:0]  tweak;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [63:0]  plaintext;

  modport master (
    output start, ciphertext, tweak, key,
    input  busy, done, plaintext
  );

  modport slave (
    input  start, ciphertext, tweak, key,
    output busy, done, plaintext
  );
endinterface

// File: rtl/craft_decrypt.sv
// Iterative CRAFT-64 decryption, one inverse round per clock.
// Each round is MC, add MC(TK) and RC, then SB(PN()) except on the final round.
module craft_decrypt #(
  parameter int ROUNDS = 32
) (
  input  logic           clk,
  input  logic           rst,
  craft_decrypt_if.slave bus
);

  localparam logic [63:0]  SBOX_TAB = 64'hCAD3EBF789150246;
  localparam logic [63:0]  PN_TAB   = 64'hFCDEA98B65471230;
  localparam logic [63:0]  Q_TAB    = 64'hCAF5E892B374601D;
  // Encryption round constants {a_i, 0, b_i}, entry i at byte i from the top.
  localparam logic [255:0] RC_TAB   =
    256'h11844225_96c763b1_54a2d5e6_f7733114_82452697_c361b452_a5d6e7f3_71341285;
  localparam logic [4:0]   LAST_J   = 5'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} fsm_t;

  function automatic logic [3:0] nib(input logic [63:0] x, input int n);
    return x[63-4*n -: 4];
  endfunction

  function automatic logic [63:0] sb64(input logic [63:0] x);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[63-4*n -: 4] = nib(SBOX_TAB, int'(nib(x, n)));
    return r;
  endfunction

  function automatic logic [63:0] perm64(input logic [63:0] x, input logic [63:0] tab);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[63-4*n -: 4] = nib(x, int'(nib(tab, n)));
    return r;
  endfunction

  function automatic logic [63:0] mc64(input logic [63:0] x);
    logic [63:0] r;
    r = x;
    for (int c = 0; c < 4; c++) begin
      r[63-4*c -: 4]     = nib(x, c) ^ nib(x, 8 + c) ^ nib(x, 12 + c);
      r[63-4*(4+c) -: 4] = nib(x, 4 + c) ^ nib(x, 12 + c);
    end
    return r;
  endfunction

  fsm_t        fsm;
  logic [63:0] st;
  logic [63:0] mtk [4];
  logic [4:0]  j;
  logic        busy_r;
  logic        done_r;
  logic [63:0] pt_r;

  logic        accept;
  logic [63:0] tq;
  logic [4:0]  ri;
  logic [7:0]  rc;
  logic [63:0] rnd_x;
  logic [63:0] rnd_out;

  // start is dropped while running and in the done cycle
  assign accept = (fsm == IDLE) && bus.start && !done_r;
  assign tq     = perm64(bus.tweak, Q_TAB);

  always_comb begin
    ri      = LAST_J - j;
    rc      = RC_TAB[255 - 8*int'(ri) -: 8];
    rnd_x   = mc64(st) ^ mtk[ri[1:0]] ^ {16'h0, rc, 40'h0};
    rnd_out = (j == LAST_J) ? rnd_x : sb64(perm64(rnd_x, PN_TAB));
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mtk[0] <= mc64(bus.key[127:64] ^ bus.tweak);
      mtk[1] <= mc64(bus.key[63:0]   ^ bus.tweak);
      mtk[2] <= mc64(bus.key[127:64] ^ tq);
      mtk[3] <= mc64(bus.key[63:0]   ^ tq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm    <= IDLE;
      st     <= '0;
      j      <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pt_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (fsm)
        IDLE: begin
          if (accept) begin
            st     <= bus.ciphertext;
            j      <= '0;
            busy_r <= 1'b1;
            fsm    <= RUN;
          end
        end
        RUN: begin
          st <= rnd_out;
          if (j == LAST_J) begin
            pt_r   <= rnd_out;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            j      <= '0;
            fsm    <= IDLE;
          end else begin
            j <= j + 5'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.plaintext = pt_r;

endmodule

// File: tb/tb_craft_decrypt.sv
// Bench for craft_decrypt: ciphertexts come from a nibble-level CRAFT-64 encryption
// model, and the core must return the original plaintext with the documented timing.
module tb_craft_decrypt;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [63:0] last_pt;

  always #5 clk = ~clk;

  craft_decrypt_if bus ();

  craft_decrypt #(.ROUNDS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [127:0] key;
    logic [63:0]  tweak;
    logic [63:0]  pt;
    bit           scramble;
  } vec_t;

  localparam int SB_T[16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
  localparam int PN_T[16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  localparam int Q_T[16]  = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  // Forward CRAFT-64 encryption with LFSR-generated round constants.
  function automatic logic [63:0] enc(input logic [63:0] p, input logic [63:0] t,
                                      input logic [127:0] k);
    logic [3:0]  s[16];
    logic [3:0]  u[16];
    logic [3:0]  tw[16];
    logic [3:0]  tk[4][16];
    logic [3:0]  a;
    logic [2:0]  b;
    logic [63:0] r;
    for (int n = 0; n < 16; n++) begin
      s[n]  = p[63-4*n -: 4];
      tw[n] = t[63-4*n -: 4];
    end
    for (int n = 0; n < 16; n++) begin
      tk[0][n] = k[127-4*n -: 4] ^ tw[n];
      tk[1][n] = k[63-4*n -: 4]  ^ tw[n];
      tk[2][n] = k[127-4*n -: 4] ^ tw[Q_T[n]];
      tk[3][n] = k[63-4*n -: 4]  ^ tw[Q_T[n]];
    end
    a = 4'h1;
    b = 3'h1;
    for (int rd = 0; rd < 32; rd++) begin
      for (int c = 0; c < 4; c++) begin
        s[c]   = s[c] ^ s[8+c] ^ s[12+c];
        s[4+c] = s[4+c] ^ s[12+c];
      end
      s[4] = s[4] ^ a;
      s[5] = s[5] ^ {1'b0, b};
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ tk[rd % 4][n];
      if (rd != 31) begin
        for (int n = 0; n < 16; n++) u[n] = s[PN_T[n]];
        for (int n = 0; n < 16; n++) s[n] = 4'(SB_T[u[n]]);
      end
      a = {a[0] ^ a[1], a[3:1]};
      b = {b[0] ^ b[1], b[2:1]};
    end
    for (int n = 0; n < 16; n++) r[63-4*n -: 4] = s[n];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [127:0] k, input logic [63:0] t, input logic [63:0] c);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.key        = k;
    bus.tweak      = t;
    bus.ciphertext = c;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered in the first cycle after capture (lat=1); returns in the done cycle.
  task automatic wait_done(input bit scramble, input logic [63:0] hold,
                           output logic [63:0] res, output int lat,
                           output int busy_n, output int hold_bad);
    lat      = 1;
    busy_n   = 0;
    hold_bad = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_n++;
      if (bus.plaintext !== hold) hold_bad++;
      if (scramble) begin
        bus.key        = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.tweak      = {$urandom(), $urandom()};
        bus.ciphertext = {$urandom(), $urandom()};
      end
      @(negedge clk);
      lat++;
    end
    res = bus.plaintext;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs[6];
    logic [63:0]  res, c, cb, p;
    logic [127:0] k;
    logic [63:0]  t;
    int           lat, busy_n, hold_bad, cnt_done, cnt_busy;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.key        = '0;
    bus.tweak      = '0;
    bus.ciphertext = '0;

    vecs[0] = '{key: 128'h27a6781a43f364bc916708d5fbb5aefe, tweak: 64'h54cd94ffd0670a58,
                pt: 64'h5734f006d8d88a3e, scramble: 1'b0};
    vecs[1] = '{key: 128'h0, tweak: 64'h0, pt: 64'h0, scramble: 1'b0};
    vecs[2] = '{key: {128{1'b1}}, tweak: {64{1'b1}}, pt: {64{1'b1}}, scramble: 1'b0};
    vecs[3] = '{key: 128'h0, tweak: 64'h0, pt: 64'h0123456789abcdef, scramble: 1'b1};
    vecs[4] = '{key: 128'h000102030405060708090a0b0c0d0e0f, tweak: 64'hfedcba9876543210,
                pt: 64'h0, scramble: 1'b1};
    vecs[5] = '{key: {{64{1'b1}}, 64'h0}, tweak: 64'h0, pt: 64'h8000000000000001,
                scramble: 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_pt", bus.plaintext, 64'h0);
    rst     = 1'b0;
    last_pt = '0;

    foreach (vecs[v]) begin
      c = enc(vecs[v].pt, vecs[v].tweak, vecs[v].key);
      launch(vecs[v].key, vecs[v].tweak, c);
      wait_done(vecs[v].scramble, last_pt, res, lat, busy_n, hold_bad);
      check($sformatf("vec%0d_pt", v), res, vecs[v].pt);
      check($sformatf("vec%0d_latency", v), lat, 33);
      check($sformatf("vec%0d_busy_cycles", v), busy_n, 32);
      check($sformatf("vec%0d_pt_hold", v), hold_bad, 0);
      last_pt = vecs[v].pt;
      @(negedge clk);
      check($sformatf("vec%0d_done_width", v), bus.done, 1'b0);
    end

    // start with new operands during round 10, then again in the done cycle
    c  = enc(64'h1122334455667788, 64'h0f0e0d0c0b0a0908, {4{32'hdeadbeef}});
    cb = enc(64'h99aabbccddeeff00, 64'h1, 128'h5);
    launch({4{32'hdeadbeef}}, 64'h0f0e0d0c0b0a0908, c);
    repeat (10) @(negedge clk);
    bus.start      = 1'b1;
    bus.key        = 128'h5;
    bus.tweak      = 64'h1;
    bus.ciphertext = cb;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1'b0, last_pt, res, lat, busy_n, hold_bad);
    check("run_start_pt", res, 64'h1122334455667788);
    check("run_start_latency", lat + 11, 33);
    last_pt   = 64'h1122334455667788;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_cycle_start_busy", bus.busy, 1'b0);
    cnt_done = 0;
    cnt_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
      if (bus.busy) cnt_busy++;
    end
    check("ignored_start_done_count", cnt_done, 0);
    check("ignored_start_busy_count", cnt_busy, 0);
    check("ignored_start_pt_hold", bus.plaintext, 64'h1122334455667788);

    // back-to-back blocks
    launch(128'h0123, 64'habcd, enc(64'hcafef00d12345678, 64'habcd, 128'h0123));
    wait_done(1'b0, last_pt, res, lat, busy_n, hold_bad);
    check("b2b_first_pt", res, 64'hcafef00d12345678);
    last_pt = 64'hcafef00d12345678;
    launch(128'h4567, 64'hef01, enc(64'h0badc0de87654321, 64'hef01, 128'h4567));
    wait_done(1'b0, last_pt, res, lat, busy_n, hold_bad);
    check("b2b_second_pt", res, 64'h0badc0de87654321);
    check("b2b_second_latency", lat, 33);
    check("b2b_first_held", hold_bad, 0);
    last_pt = 64'h0badc0de87654321;

    // reset during round 17
    launch(128'h77, 64'h88, enc(64'h5555aaaa5555aaaa, 64'h88, 128'h77));
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_pt", bus.plaintext, 64'h0);
    check("midrst_done", bus.done, 1'b0);
    cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
    end
    check("midrst_no_done", cnt_done, 0);
    last_pt = '0;

    // reset wins over a simultaneous start
    bus.start = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("rst_start_busy", bus.busy, 1'b0);

    launch(128'h99, 64'haa, enc(64'h13579bdf2468ace0, 64'haa, 128'h99));
    wait_done(1'b0, last_pt, res, lat, busy_n, hold_bad);
    check("postrst_pt", res, 64'h13579bdf2468ace0);
    check("postrst_latency", lat, 33);
    check("postrst_pt_zero_hold", hold_bad, 0);
    last_pt = 64'h13579bdf2468ace0;

    for (int i = 0; i < 1000; i++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      t = {$urandom(), $urandom()};
      p = {$urandom(), $urandom()};
      launch(k, t, enc(p, t, k));
      wait_done(i[0], last_pt, res, lat, busy_n, hold_bad);
      check($sformatf("rand%0d_pt", i), res, p);
      check($sformatf("rand%0d_latency", i), lat, 33);
      last_pt = p;
      @(negedge clk);
      check($sformatf("rand%0d_done_width", i), bus.done, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
